// File: rtl/fetch_queue.sv
// Circular-buffer fetch queue between instruction fetch and decode.
// Entries become visible to decode one cycle after they are pushed.
module fetch_queue #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       INST_W     = 32,
    parameter int unsigned       DEPTH      = 4,
    parameter logic [INST_W-1:0] FLUSH_INST = INST_W'(32'h00000013)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rdy,
    input  logic                         flush,
    input  logic                         if_valid,
    input  logic [ADDR_W-1:0]            if_pc,
    input  logic [ADDR_W-1:0]            if_npc,
    input  logic [INST_W-1:0]            if_inst,
    input  logic [ADDR_W-1:0]            if_pred,
    output logic                         if_ready,
    output logic                         id_valid,
    output logic [ADDR_W-1:0]            id_pc,
    output logic [ADDR_W-1:0]            id_npc,
    output logic [INST_W-1:0]            id_inst,
    output logic [ADDR_W-1:0]            id_pred,
    input  logic                         id_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] npc;
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pred;
    } entry_t;

    entry_t             entries_q [DEPTH];
    entry_t             entries_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic not_full;
    logic not_empty;
    logic push;
    logic pop;
    entry_t head_entry;

    assign not_full   = (count_q < FULL_CNT);
    assign not_empty  = (count_q != '0);
    assign push       = if_valid && not_full && rdy && !flush;
    assign pop        = not_empty && id_ready && rdy && !flush;
    assign head_entry = entries_q[head_q];

    // Flush wins over push/pop; rdy low freezes every pointer and the count.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy && flush) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        entries_d = entries_q;
        if (push) begin
            entries_d[tail_q] = '{pc: if_pc, npc: if_npc, inst: if_inst, pred: if_pred};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is never cleared; the count alone decides which slots are live.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    // Outputs are masked while rst_n is low so reset behaviour is visible at once.
    always_comb begin
        count    = count_q;
        if_ready = !rst_n || not_full;
        id_valid = rst_n && not_empty;
        id_pc    = '0;
        id_npc   = '0;
        id_pred  = '0;
        id_inst  = FLUSH_INST;
        if (rst_n && not_empty) begin
            id_pc   = head_entry.pc;
            id_npc  = head_entry.npc;
            id_inst = head_entry.inst;
            id_pred = head_entry.pred;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard testbench for fetch_queue: expected entries are queued on push
// and compared against the head when decode consumes them.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n, rdy, flush;
    logic        if_valid, if_ready, id_valid, id_ready;
    logic [31:0] if_pc, if_npc, if_inst, if_pred;
    logic [31:0] id_pc, id_npc, id_inst, id_pred;
    logic [2:0]  count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
        logic [31:0] pred;
    } ent_t;

    ent_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .FLUSH_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .if_valid(if_valid), .if_pc(if_pc), .if_npc(if_npc), .if_inst(if_inst), .if_pred(if_pred),
        .if_ready(if_ready),
        .id_valid(id_valid), .id_pc(id_pc), .id_npc(id_npc), .id_inst(id_inst), .id_pred(id_pred),
        .id_ready(id_ready), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mkInst(input logic [31:0] pc);
        return (pc * 32'd3) ^ 32'hDEAD0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Drives one cycle of inputs, checks outputs at the falling edge, then
    // advances the reference model across the rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic rdv,
                                 input logic fl, input logic rdyv, input logic rstv);
        int   n;
        logic exp_valid, do_push, do_pop;
        ent_t e;
        if_valid = v;
        if_pc    = pc;
        if_npc   = pc + 32'd4;
        if_inst  = mkInst(pc);
        if_pred  = pc + 32'h40;
        id_ready = rdv;
        flush    = fl;
        rdy      = rdyv;
        rst_n    = rstv;
        @(negedge clk);
        n         = exp_q.size();
        exp_valid = rstv && (n > 0);
        if (rstv) checkOutput("count", 64'(count), 64'(n));
        checkOutput("if_ready", 64'(if_ready), 64'(!rstv || (n < DEPTH)));
        checkOutput("id_valid", 64'(id_valid), 64'(exp_valid));
        if (exp_valid) begin
            checkOutput("id_pc", 64'(id_pc), 64'(exp_q[0].pc));
            checkOutput("id_npc", 64'(id_npc), 64'(exp_q[0].npc));
            checkOutput("id_inst", 64'(id_inst), 64'(exp_q[0].inst));
            checkOutput("id_pred", 64'(id_pred), 64'(exp_q[0].pred));
        end else begin
            checkOutput("empty_inst", 64'(id_inst), 64'(NOP));
            checkOutput("empty_pc", 64'(id_pc), 64'd0);
            checkOutput("empty_npc", 64'(id_npc), 64'd0);
            checkOutput("empty_pred", 64'(id_pred), 64'd0);
        end
        do_push = rstv && v && (n < DEPTH) && rdyv && !fl;
        do_pop  = rstv && (n > 0) && rdv && rdyv && !fl;
        @(posedge clk);
        #1;
        if (!rstv || (rdyv && fl)) begin
            exp_q.delete();
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                e.pc   = pc;
                e.npc  = pc + 32'd4;
                e.inst = mkInst(pc);
                e.pred = pc + 32'h40;
                exp_q.push_back(e);
            end
        end
    endtask

    initial begin
        logic [31:0] pc;
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        if_pc = '0; if_npc = '0; if_inst = '0; if_pred = '0;

        $display("[TB] reset");
        applyStimulus(0, 32'h0, 0, 0, 1, 0);
        applyStimulus(1, 32'h50, 1, 1, 0, 0);
        applyStimulus(0, 32'h0, 0, 0, 1, 1);

        $display("[TB] three pushes without pop");
        applyStimulus(1, 32'h100, 0, 0, 1, 1);
        applyStimulus(1, 32'h104, 0, 0, 1, 1);
        applyStimulus(1, 32'h108, 0, 0, 1, 1);

        $display("[TB] full queue blocks push during pop");
        applyStimulus(1, 32'h10C, 0, 0, 1, 1);
        applyStimulus(1, 32'h200, 1, 0, 1, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 1, 0, 1, 1);

        $display("[TB] flush with push and pop pending");
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'h300 + 32'(i * 4), 0, 0, 1, 1);
        applyStimulus(1, 32'h400, 1, 1, 1, 1);
        applyStimulus(0, 32'h0, 0, 0, 1, 1);

        $display("[TB] streaming across pointer wrap");
        for (int i = 0; i < 10; i++) applyStimulus(1, 32'h500 + 32'(i * 4), 1, 0, 1, 1);
        for (int i = 0; i < 2; i++) applyStimulus(0, 32'h0, 1, 0, 1, 1);

        $display("[TB] rdy low freezes state");
        applyStimulus(1, 32'h600, 0, 0, 1, 1);
        applyStimulus(1, 32'h604, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'h700, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 1, 0, 1, 1);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'h800 + 32'(i * 4), 0, 0, 1, 1);
        applyStimulus(0, 32'h0, 0, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 0, 1, 1);

        $display("[TB] random traffic");
        pc = 32'h1000;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) != 0), 1'b1);
            pc = pc + 32'd4;
        end
        for (int i = 0; i < 5; i++) applyStimulus(0, 32'h0, 1, 0, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
